// File: rtl/kuznechik_l_transform_seq_if.sv
// kuznechik_l_transform_seq_if: valid/ready block bus for the L transform (in_inv only with KUZNECHIK_L_INV_EN)
interface kuznechik_l_transform_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
`ifdef KUZNECHIK_L_INV_EN
  logic         in_inv;
  modport master (output in_valid, in_data, out_ready, in_inv, input in_ready, out_valid, out_data, busy);
  modport slave  (input in_valid, in_data, out_ready, in_inv, output in_ready, out_valid, out_data, busy);
`else
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, busy);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, busy);
`endif
endinterface

// File: rtl/kuznechik_l_transform_seq.sv
// kuznechik_l_transform_seq: Kuznyechik L = R^ROUNDS, one R step per clock; KUZNECHIK_L_INV_EN adds the inverse mode
module kuznechik_l_transform_seq #(
  parameter int ROUNDS = 16
) (
  input logic                           clk,
  input logic                           rst_n,
  kuznechik_l_transform_seq_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // l() coefficients, byte a15 in the top slot down to a0 in the bottom slot
  localparam logic [127:0] COEF = {8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                                   8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};
  localparam logic [4:0] LAST = 5'(ROUNDS - 1);
  if (ROUNDS < 1 || ROUNDS > 16) begin : g_bad_rounds
    $error("ROUNDS must be in 1..16");
  end
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
    end
    return p;
  endfunction
  function automatic logic [7:0] l_fn(input logic [127:0] a);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r ^= gf_mul(a[8*i +: 8], COEF[8*i +: 8]);
    return r;
  endfunction
  state_t       state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] step;
  logic         last;
`ifdef KUZNECHIK_L_INV_EN
  logic         inv_q, inv_d;
  // inverse step rotates left with the new byte entering at the bottom
  always_comb step = inv_q ? {data_q[119:0], l_fn({data_q[119:0], data_q[127:120]})}
                           : {l_fn(data_q), data_q[127:8]};
`else
  // forward step shifts right with the new byte entering at the top
  always_comb step = {l_fn(data_q), data_q[127:8]};
`endif
  assign last = (cnt_q == LAST);
  // next-state: accept in IDLE, one R per RUN cycle, hold result in DONE until taken
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef KUZNECHIK_L_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = RUN;
        data_d  = bus.in_data;
        cnt_d   = '0;
`ifdef KUZNECHIK_L_INV_EN
        inv_d   = bus.in_inv;
`endif
      end
      RUN: begin
        data_d  = step;
        cnt_d   = last ? cnt_q : cnt_q + 5'd1;
        state_d = last ? DONE : RUN;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state, block register and iteration counter; reset discards any block in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef KUZNECHIK_L_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef KUZNECHIK_L_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_data  = data_q;
endmodule

// File: tb/tb_kuznechik_l_transform_seq.sv
// tb_kuznechik_l_transform_seq: directed checks of the L transform against the GOST test vectors
module tb_kuznechik_l_transform_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  kuznechik_l_transform_seq_if bus ();
  kuznechik_l_transform_seq_if bus1 ();
  kuznechik_l_transform_seq #(.ROUNDS(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  kuznechik_l_transform_seq #(.ROUNDS(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  localparam logic [127:0] V0 = 128'h64a59400000000000000000000000000;
  localparam logic [127:0] V1 = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
  localparam logic [127:0] V2 = 128'h79d26221b87b584cd42fbc4ffea5de9a;
  localparam logic [127:0] V3 = 128'h0e93691a0cfc60408b7b68f66b513c13;
  localparam logic [127:0] V4 = 128'he6a8094fee0aa204fd97bcb0b44b8580;
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [127:0] d, output int acc);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  initial begin
    int acc, prev, lat, seen;
    logic [127:0] ins [4];
    logic [127:0] exps [4];
    logic [127:0] held;
    ins  = '{V1, V2, V3, V0};
    exps = '{V2, V3, V4, V1};
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    bus1.in_valid = 0; bus1.in_data = '0; bus1.out_ready = 0;
`ifdef KUZNECHIK_L_INV_EN
    bus.in_inv = 0; bus1.in_inv = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_data", bus.out_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single full-L block and its latency
    bus.out_ready = 1'b1;
    send(V0, acc);
    check("busy_after_accept", bus.busy, 1);
    wait_done(lat);
    check("latency16", lat, 16);
    check("L(V0)", bus.out_data, V1);
    // chained blocks with out_ready held high
    prev = acc;
    for (int i = 0; i < 3; i++) begin
      send(ins[i], acc);
      check("chain_spacing", acc - prev, 18);
      prev = acc;
      wait_done(lat);
      check("chain_data", bus.out_data, exps[i]);
    end
    // ROUNDS=1 instance
    bus1.out_ready = 1'b1;
    bus1.in_data = 128'h00000000000000000000000000000100;
    bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    check("r1_not_yet", bus1.out_valid, 0);
    lat = 0;
    while (!bus1.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("r1_latency", lat, 1);
    check("r1_data", bus1.out_data, 128'h94000000000000000000000000000001);
    // backpressure in DONE
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    send(V1, acc);
    wait_done(lat);
    held = bus.out_data;
    check("bp_data", held, V2);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, held);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", bus.in_ready, 1);
    check("bp_release_out_valid", bus.out_valid, 0);
    // reset in the middle of RUN (cnt=7)
    send(V2, acc);
    repeat (7) @(posedge clk);
    #1;
    check("mid_run_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_out_data", bus.out_data, 0);
    #5;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("no_spurious_valid", seen, 0);
    send(V0, acc);
    wait_done(lat);
    check("post_rst_latency", lat, 16);
    check("post_rst_data", bus.out_data, V1);
`ifdef KUZNECHIK_L_INV_EN
    // inverse block followed by a forward block
    bus.in_inv = 1'b1;
    send(V1, acc);
    bus.in_inv = 1'b0;
    wait_done(lat);
    check("inv_data", bus.out_data, V0);
    send(V3, acc);
    wait_done(lat);
    check("fwd_after_inv", bus.out_data, V4);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
